// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline types for hazard tracking: result kinds, shadow slots and
// multi-cycle latencies.
package hazard_ctrl_pkg;

    typedef logic [4:0] creg_addr_t;

    typedef enum logic [1:0] {
        RK_ALU  = 2'd0,
        RK_LOAD = 2'd1,
        RK_MUL  = 2'd2,
        RK_DIV  = 2'd3
    } res_kind_t;

    typedef struct packed {
        logic       valid;
        creg_addr_t wa;
        logic       wen;
        res_kind_t  kind;
    } hz_slot_t;

    typedef enum logic [2:0] {
        HZ_MEM   = 3'd0,
        HZ_MD    = 3'd1,
        HZ_FLUSH = 3'd2,
        HZ_LDUSE = 3'd3,
        HZ_RUN   = 3'd4
    } hz_case_t;

    localparam int MUL_LAT_DEF = 3;
    localparam int DIV_LAT_DEF = 65;
    localparam int CNT_W       = 7;

    localparam hz_slot_t SLOT_EMPTY = '{valid: 1'b0, wa: 5'd0, wen: 1'b0, kind: RK_ALU};

    // A source read hits a slot only for a real write to a non-zero register.
    function automatic logic src_hit(input creg_addr_t ra, input logic used, input hz_slot_t s);
        return used && (ra != 5'd0) && s.valid && s.wen && (s.wa == ra);
    endfunction

endpackage

// File: rtl/hazard_ctrl_md_counter.sv
// Occupancy counter for multi-cycle units: loads a count, decrements to zero,
// busy while non-zero.
module md_counter #(
    parameter int W = 7
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         busy_o
);

    logic [W-1:0] cnt_q;

    // Count register: load wins over decrement; stops at zero.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= {W{1'b0}};
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != {W{1'b0}}) begin
            cnt_q <= cnt_q - {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign busy_o = (cnt_q != {W{1'b0}});

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard control for the 5-stage pipeline: tracks in-flight writes in E/M/W and
// produces stall/bubble controls for load-use, mul/div occupancy, D-cache and flush.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       d_valid,
    input  creg_addr_t d_ra1,
    input  logic       d_use1,
    input  creg_addr_t d_ra2,
    input  logic       d_use2,
    input  creg_addr_t d_wa,
    input  logic       d_wen,
    input  logic [1:0] d_kind,
    input  logic       mem_stall,
    input  logic       e_flush,
    output logic       stall_d,
    output logic       stall_e,
    output logic       stall_m,
    output logic       bubble_e,
    output logic       bubble_m,
    output logic       bubble_w,
    output logic       md_busy,
    output hz_slot_t   e_slot,
    output hz_slot_t   m_slot,
    output hz_slot_t   w_slot
);

    localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_LAT - 1);

    hz_slot_t         e_q, e_d, m_q, m_d, w_q, w_d;
    hz_slot_t         d_slot_s;
    logic             flush_pend_q, flush_pend_d;
    logic             ld_use_s, md_load_s;
    logic [CNT_W-1:0] md_ld_val_s;
    hz_case_t         case_s;

    // Decode-stage instruction as it would be recorded in slot e.
    always_comb begin
        d_slot_s.valid = d_valid;
        d_slot_s.wa    = d_wa;
        d_slot_s.wen   = d_wen & d_valid & (d_wa != 5'd0);
        d_slot_s.kind  = res_kind_t'(d_kind);
    end

    assign ld_use_s = d_valid && (e_q.kind == RK_LOAD) &&
                      (src_hit(d_ra1, d_use1, e_q) || src_hit(d_ra2, d_use2, e_q));

    // Priority selection of the active hazard case.
    always_comb begin
        if (mem_stall) begin
            case_s = HZ_MEM;
        end else if (md_busy) begin
            case_s = HZ_MD;
        end else if (e_flush || flush_pend_q) begin
            case_s = HZ_FLUSH;
        end else if (ld_use_s) begin
            case_s = HZ_LDUSE;
        end else begin
            case_s = HZ_RUN;
        end
    end

    // Stage controls and next shadow-slot contents for the selected case.
    always_comb begin
        stall_d      = 1'b0;
        stall_e      = 1'b0;
        stall_m      = 1'b0;
        bubble_e     = 1'b0;
        bubble_m     = 1'b0;
        bubble_w     = 1'b0;
        e_d          = e_q;
        m_d          = m_q;
        w_d          = w_q;
        flush_pend_d = flush_pend_q;
        case (case_s)
            HZ_MEM: begin
                stall_d      = 1'b1;
                stall_e      = 1'b1;
                stall_m      = 1'b1;
                bubble_w     = 1'b1;
                w_d          = SLOT_EMPTY;
                flush_pend_d = flush_pend_q | e_flush;
            end
            HZ_MD: begin
                stall_d      = 1'b1;
                stall_e      = 1'b1;
                bubble_m     = 1'b1;
                m_d          = SLOT_EMPTY;
                w_d          = m_q;
                flush_pend_d = flush_pend_q | e_flush;
            end
            HZ_FLUSH: begin
                bubble_e     = 1'b1;
                e_d          = SLOT_EMPTY;
                m_d          = e_q;
                w_d          = m_q;
                flush_pend_d = 1'b0;
            end
            HZ_LDUSE: begin
                stall_d  = 1'b1;
                bubble_e = 1'b1;
                e_d      = SLOT_EMPTY;
                m_d      = e_q;
                w_d      = m_q;
            end
            HZ_RUN: begin
                e_d = d_slot_s;
                m_d = e_q;
                w_d = m_q;
            end
            default: begin
                e_d = e_q;
            end
        endcase
    end

    // A MUL/DIV entering E arms the occupancy counter with its latency minus one.
    always_comb begin
        md_load_s = (case_s == HZ_RUN) && d_valid &&
                    ((d_slot_s.kind == RK_MUL) || (d_slot_s.kind == RK_DIV));
        if (d_slot_s.kind == RK_DIV) begin
            md_ld_val_s = DIV_LD;
        end else begin
            md_ld_val_s = MUL_LD;
        end
    end

    md_counter #(
        .W(CNT_W)
    ) u_md_counter (
        .clk_i      (clk),
        .reset_i    (reset),
        .load_i     (md_load_s),
        .load_val_i (md_ld_val_s),
        .busy_o     (md_busy)
    );

    // Shadow slot and pending-flush registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_q          <= SLOT_EMPTY;
            m_q          <= SLOT_EMPTY;
            w_q          <= SLOT_EMPTY;
            flush_pend_q <= 1'b0;
        end else begin
            e_q          <= e_d;
            m_q          <= m_d;
            w_q          <= w_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    assign e_slot = e_q;
    assign m_slot = m_q;
    assign w_slot = w_q;

endmodule
